// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared types and sizing helpers for the SPI register bank.
// Holds the frame FSM state enum and frame/counter width functions.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    DONE
  } state_t;

  function automatic int frame_len(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

  function automatic int cnt_w(input int aw, input int dw);
    return $clog2(frame_len(aw, dw) + 1);
  endfunction

endpackage

// File: rtl/spi_reg_bank_sync.sv
// spi_sync_edge: 2-flop synchroniser for one async SPI pin.
// Edges come from the synced value and its 1-cycle-delayed copy.
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [2:0] sh_q;
  logic [2:0] sh_d;

  // shift the pin through meta, sync and delayed stages
  always_comb begin
    sh_d = {sh_q[1:0], d};
  end

  // synchroniser register
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign sync = sh_q[1];
  assign rise = sh_q[1] & ~sh_q[2];
  assign fall = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 register bank with readback and abort counter.
// Optional SPI_BURST_EN: extra words auto-increment the register address.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int NUM_REGS = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int ERR_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sclk,
  input  logic                     ncs,
  input  logic                     copi,
  output logic                     cipo,
  output logic                     cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]      wr_pulse,
  output logic [ERR_CNT_W-1:0]     err_cnt
);

  localparam int CW = cnt_w(ADDR_W, DATA_W);

  logic sclk_s, sclk_rise, sclk_fall;
  logic ncs_s, ncs_rise, ncs_fall;
  logic copi_s, copi_rise, copi_fall;
  logic unused_sync;

  spi_sync_edge u_sclk (
    .clk(clk), .rst(rst), .d(sclk),
    .sync(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge u_ncs (
    .clk(clk), .rst(rst), .d(ncs),
    .sync(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
  );
  spi_sync_edge u_copi (
    .clk(clk), .rst(rst), .d(copi),
    .sync(copi_s), .rise(copi_rise), .fall(copi_fall)
  );

  assign unused_sync = ^{sclk_s, ncs_s, copi_rise, copi_fall};

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, addr_nx, look_a;
  logic [DATA_W-1:0]   sh_q, sh_d, so_q, so_d, data_nx, look_v;
  logic                cipo_q, cipo_d, oe_q, oe_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_q, wr_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic                in_data;

  assign addr_nx = ADDR_W'({addr_q, copi_s});
  assign data_nx = DATA_W'({sh_q, copi_s});

  // readback source: addressed register, or 0 when out of range
  always_comb begin
    look_a = (state_q == CMD) ? addr_nx : addr_q + 1'b1;
    look_v = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (look_a == ADDR_W'(i)) look_v = regs_q[i];
    end
  end

  // frame FSM: edges first, then ncs release / abort accounting
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    sh_d    = sh_q;
    so_d    = so_q;
    cipo_d  = cipo_q;
    oe_d    = oe_q;
    err_d   = err_q;
    regs_d  = regs_q;
    wr_d    = '0;
    in_data = (state_q == DATA);
`ifdef SPI_BURST_EN
    in_data = in_data || (state_q == DONE);
`endif
    unique case (1'b1)
      (state_q == IDLE): begin
        if (ncs_fall) begin
          state_d = CMD;
          cnt_d   = '0;
          rw_d    = 1'b0;
          addr_d  = '0;
          sh_d    = '0;
          cipo_d  = 1'b0;
          oe_d    = 1'b0;
        end
      end
      (state_q == CMD): begin
        if (sclk_rise) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '0) rw_d = copi_s;
          else addr_d = addr_nx;
          if (cnt_q == CW'(ADDR_W)) begin
            state_d = DATA;
            cnt_d   = '0;
            if (!rw_q) so_d = look_v;
          end
        end
      end
      in_data: begin
        if (sclk_rise) begin
          sh_d  = data_nx;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(DATA_W - 1)) begin
            state_d = DONE;
            cnt_d   = '0;
            for (int i = 0; i < NUM_REGS; i++) begin
              if (rw_q && addr_q == ADDR_W'(i)) begin
                regs_d[i] = data_nx;
                wr_d[i]   = 1'b1;
              end
            end
`ifdef SPI_BURST_EN
            addr_d = addr_q + 1'b1;
            if (!rw_q) so_d = look_v;
`endif
          end
        end else if (sclk_fall && !rw_q) begin
          cipo_d = so_q[DATA_W-1];
          so_d   = so_q << 1;
          oe_d   = 1'b1;
        end
      end
      default: begin
      end
    endcase
    if (ncs_rise && state_q != IDLE) begin
      if ((state_d == CMD || state_d == DATA) && !(&err_q)) begin
        err_d = err_q + 1'b1;
      end
      state_d = IDLE;
      oe_d    = 1'b0;
      cipo_d  = 1'b0;
    end
  end

  // state and register-file flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      sh_q    <= '0;
      so_q    <= '0;
      cipo_q  <= 1'b0;
      oe_q    <= 1'b0;
      err_q   <= '0;
      wr_q    <= '0;
      regs_q  <= '{default: RESET_VAL};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      sh_q    <= sh_d;
      so_q    <= so_d;
      cipo_q  <= cipo_d;
      oe_q    <= oe_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      regs_q  <= regs_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_q[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign cipo     = cipo_q;
  assign cipo_oe  = oe_q;
  assign wr_pulse = wr_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: directed plus random SPI frames against a register model.
// Bit-banged mode-0 controller; model tracks registers, strobes, aborts.
module tb_spi_reg_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        ncs = 1'b1;
  logic        copi = 1'b0;
  logic        cipo, cipo_oe;
  logic [63:0] reg_q;
  logic [7:0]  wr_pulse;
  logic [7:0]  err_cnt;

  spi_reg_bank dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ncs(ncs), .copi(copi),
    .cipo(cipo), .cipo_oe(cipo_oe), .reg_q(reg_q),
    .wr_pulse(wr_pulse), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int pcnt [8];
  int p0 [8];
  logic [7:0] model [8];
  int em = 0;

  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) if (wr_pulse[i]) pcnt[i]++;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [63:0] flat();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = model[i];
    return v;
  endfunction

  function automatic logic [63:0] pdiff();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = 8'(pcnt[i] - p0[i]);
    return v;
  endfunction

  function automatic logic [63:0] pone(input int a);
    logic [63:0] v = '0;
    if (a >= 0 && a < 8) v[a*8 +: 8] = 8'd1;
    return v;
  endfunction

  function automatic void abort_model();
    if (em < 255) em++;
  endfunction

  // send first 'send' bits of a 'len'-bit frame; rst pulsed at bit rst_at
  task automatic frame(input logic [39:0] bits, input int len,
                       input int send, input int rst_at,
                       output logic [31:0] rd, output bit oe_all,
                       output bit oe_any);
    for (int i = 0; i < 8; i++) p0[i] = pcnt[i];
    rd = '0;
    oe_all = 1'b1;
    oe_any = 1'b0;
    ncs = 1'b0;
    wait_clk(6);
    for (int j = 0; j < send; j++) begin
      if (j == rst_at) begin
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
      end
      copi = bits[len-1-j];
      wait_clk(6);
      if (j >= 8) begin
        rd = {rd[30:0], cipo};
        oe_all = oe_all & cipo_oe;
      end
      oe_any = oe_any | cipo_oe;
      sclk = 1'b1;
      wait_clk(6);
      sclk = 1'b0;
    end
    wait_clk(6);
    ncs = 1'b1;
    wait_clk(8);
  endtask

  initial begin
    logic [39:0] bits;
    logic [31:0] rd;
    bit oa, on;
    logic rw;
    logic [6:0] ad;
    logic [7:0] dt;
    int send;

    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(2);
    chk("rst_regs", reg_q, flat());
    chk("rst_err", 64'(err_cnt), 64'(em));
    chk("rst_oe", 64'(cipo_oe), 64'd0);
    chk("rst_cipo", 64'(cipo), 64'd0);
    chk("rst_wr", 64'(wr_pulse), 64'd0);

    bits = 40'({1'b1, 7'd1, 8'h77});
    frame(bits, 16, 16, 12, rd, oa, on);
    chk("midrst_regs", reg_q, flat());
    chk("midrst_err", 64'(err_cnt), 64'(em));
    chk("midrst_pulse", pdiff(), 64'd0);

    bits = 40'({1'b1, 7'd3, 8'hA5});
    frame(bits, 16, 16, -1, rd, oa, on);
    model[3] = 8'hA5;
    chk("wr3_regs", reg_q, flat());
    chk("wr3_pulse", pdiff(), pone(3));
    chk("wr3_oe", 64'(on), 64'd0);

    bits = 40'({1'b1, 7'd3, 8'h5A});
    frame(bits, 16, 16, -1, rd, oa, on);
    model[3] = 8'h5A;
    bits = 40'({1'b0, 7'd3, 8'h00});
    frame(bits, 16, 16, -1, rd, oa, on);
    chk("rd3_data", 64'(rd[7:0]), 64'(model[3]));
    chk("rd3_oe", 64'(oa), 64'd1);
    chk("rd3_oe_off", 64'(cipo_oe), 64'd0);

    bits = 40'({1'b0, 7'd100, 8'h00});
    frame(bits, 16, 16, -1, rd, oa, on);
    chk("rd100_data", 64'(rd[7:0]), 64'd0);

    bits = 40'({1'b1, 7'd9, 8'hFF});
    frame(bits, 16, 16, -1, rd, oa, on);
    chk("wr9_regs", reg_q, flat());
    chk("wr9_pulse", pdiff(), 64'd0);
    chk("wr9_err", 64'(err_cnt), 64'(em));

    bits = 40'({1'b1, 7'd2, 8'hC3});
    frame(bits, 16, 10, -1, rd, oa, on);
    abort_model();
    chk("abort_regs", reg_q, flat());
    chk("abort_err", 64'(err_cnt), 64'(em));
    chk("abort_pulse", pdiff(), 64'd0);

    for (int k = 0; k < 300; k++) begin
      bits = 40'($urandom);
      frame(bits, 16, $urandom_range(0, 4), -1, rd, oa, on);
      abort_model();
    end
    chk("sat_err", 64'(err_cnt), 64'(em));

    for (int k = 0; k < 40; k++) begin
      rw = 1'($urandom_range(0, 1));
      ad = 7'($urandom_range(0, 15));
      dt = 8'($urandom);
      send = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 16;
      bits = 40'({rw, ad, dt});
      frame(bits, 16, send, -1, rd, oa, on);
      if (send < 16) begin
        abort_model();
        chk("rnd_abort_pulse", pdiff(), 64'd0);
      end else if (rw) begin
        if (ad < 8) model[ad] = dt;
        chk("rnd_wr_pulse", pdiff(), (ad < 8) ? pone(int'(ad)) : 64'd0);
        chk("rnd_wr_oe", 64'(on), 64'd0);
      end else begin
        chk("rnd_rd_data", 64'(rd[7:0]),
            (ad < 8) ? 64'(model[ad]) : 64'd0);
        chk("rnd_rd_oe", 64'(oa), 64'd1);
      end
      chk("rnd_regs", reg_q, flat());
      chk("rnd_err", 64'(err_cnt), 64'(em));
    end

    bits = 40'({1'b1, 7'd6, 8'h11, 8'h22, 8'h33});
    frame(bits, 32, 32, -1, rd, oa, on);
    model[6] = 8'h11;
`ifdef SPI_BURST_EN
    model[7] = 8'h22;
    chk("burst_pulse", pdiff(), pone(6) | pone(7));
`else
    chk("burst_pulse", pdiff(), pone(6));
`endif
    chk("burst_regs", reg_q, flat());
    chk("burst_err", 64'(err_cnt), 64'(em));

    bits = 40'({1'b0, 7'd6, 24'h0});
    frame(bits, 32, 32, -1, rd, oa, on);
`ifdef SPI_BURST_EN
    chk("burst_rd", 64'(rd[23:0]), 64'({model[6], model[7], 8'h00}));
`else
    chk("burst_rd", 64'(rd[23:16]), 64'(model[6]));
`endif
    chk("burst_rd_err", 64'(err_cnt), 64'(em));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
Parametrised SPI (mode 0) peripheral register bank that generalises the five-register write-only SPI peripheral. It adds configurable width and depth, register readback on cipo, per-register write strobes and an aborted-frame counter. All SPI inputs are asynchronous and are sampled in the clk domain. The block sits between the chip pins and the PWM/output-enable logic, which consume the reg_q bus.

Parameters:
ADDR_W, 7, address field width in bits
DATA_W, 8, register and data-field width in bits
NUM_REGS, 8, implemented registers, addresses 0..NUM_REGS-1; must satisfy NUM_REGS <= 2**ADDR_W
RESET_VAL, 0, value (DATA_W bits) loaded into every register on reset
ERR_CNT_W, 8, width of the aborted-frame counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
sclk  in  1  SPI clock, asynchronous
ncs  in  1  SPI chip select, active-low, asynchronous
copi  in  1  SPI data from controller, asynchronous
cipo  out  1  SPI data to controller
cipo_oe  out  1  output enable for the cipo pad
reg_q  out  NUM_REGS*DATA_W  flattened register contents; register i occupies bits [i*DATA_W +: DATA_W]
wr_pulse  out  NUM_REGS  one-clk strobe on the cycle register i is written
err_cnt  out  ERR_CNT_W  count of aborted frames, saturating

Behaviour:
- Reset values: reg_q = RESET_VAL in every field; wr_pulse = 0; cipo = 0; cipo_oe = 0; err_cnt = 0; FSM = IDLE; bit counter = 0.
- Reset mid-frame: the frame is discarded, no write occurs and err_cnt is not incremented. Decoding resumes at the next ncs falling edge.
- Input synchronisation: sclk, ncs and copi each pass through a 2-flop synchroniser. Edges are detected from the synchronised value and its 1-cycle-delayed copy.
- Required SCLK timing: high and low phases of at least 4 clk cycles each.
- Frame format, MSB first, sampled on sclk rising edges: 1 R/W bit (1 = write), then ADDR_W address bits, then DATA_W data bits. FRAME_LEN = 1 + ADDR_W + DATA_W.
- FSM states:
  - IDLE: waits for an ncs falling edge, then goes to CMD with counter = 0 and the shift register cleared.
  - CMD: shifts in the R/W bit and address bits. After bit ADDR_W goes to DATA. On a read, loads the shift-out register with reg[addr], or with 0 if addr >= NUM_REGS.
  - DATA: shifts in DATA_W bits. A write to a valid address commits reg[addr] on the clk cycle after the last rising edge is detected, and wr_pulse[addr] is high for exactly that cycle. A write with addr >= NUM_REGS is silently dropped (no strobe). After the data phase goes to DONE.
  - DONE: ignores all sclk edges until ncs rises.
- Any state: on an ncs rising edge, return to IDLE and set cipo_oe = 0.
  - If the FSM is in CMD, or in DATA with fewer than DATA_W bits received, err_cnt increments, saturating at all-ones.
  - A partial write never commits.
- Read output: cipo_oe = 1 from the first sclk falling edge in DATA until ncs rises. On each sclk falling edge in DATA, cipo takes the next shift-out bit, MSB first. During write frames cipo stays 0 with cipo_oe = 0.
- Simultaneous events: when the final sclk rising edge and an ncs rising edge are detected in the same clk cycle, the edge is processed first. The frame counts as complete, the write commits and err_cnt is unchanged.
- Bits received while ncs is high are ignored.
- Readback returns the value committed before the current frame.

Optional Feature:
SPI_BURST_EN
- Defined: in DONE, if ncs stays low, each further DATA_W bits address the next register, with addr+1 wrapping modulo 2**ADDR_W.
  - Writes commit per word, with their own wr_pulse.
  - Reads preload the next register, or 0 for an invalid address, on the rising edge that completes the previous word.
  - A partial trailing word is discarded without incrementing err_cnt.
- Undefined: extra bits are ignored exactly as in DONE.

Decomposition:
- Package spi_reg_pkg holds: the FSM state enum (IDLE, CMD, DATA, DONE), and constant functions for FRAME_LEN and the counter width ($clog2(FRAME_LEN+1)).
- Sub-module spi_sync_edge (one instance per SPI input) holds the 2-flop synchroniser plus rise/fall detection. It outputs sync, rise and fall.

Test Plan:
- Reset: assert rst for 2 cycles -> reg_q all RESET_VAL, err_cnt = 0, cipo_oe = 0.
- Write frame W, addr 3, data 0xA5 -> reg 3 = 0xA5, wr_pulse[3] high exactly 1 cycle, other registers unchanged.
- Write addr 3 = 0x5A, then read addr 3 -> cipo shifts out 0x5A MSB first with cipo_oe = 1. A read of addr 100 returns 0x00.
- Write addr 9 (>= NUM_REGS) with data 0xFF -> no wr_pulse, reg_q unchanged, err_cnt unchanged.
- Abort: raise ncs after 10 of 16 bits -> no write, err_cnt = 1. Then 300 aborted frames -> err_cnt = 255 (saturated).
- Burst (SPI_BURST_EN): write start addr 6, then 3 data words 0x11, 0x22, 0x33 with NUM_REGS=8 -> reg6 = 0x11, reg7 = 0x22. The third word targets addr 8, which is invalid and dropped. Without the macro only reg6 is written.
